// File: rtl/bus8051_master.sv
// 8051-style multiplexed-address bus initiator driving cs_n/ale/w_n/r_n/abus/dbus.
// Optional 4-entry command FIFO enabled by BUS8051_MASTER_QUEUE_EN.
module bus8051_master #(
  parameter int ALE_CYCLES = 2,
  parameter int STB_CYCLES = 4,
  parameter int REC_CYCLES = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        cs_n,
  output logic        ale,
  output logic        w_n,
  output logic        r_n,
  output logic [7:0]  abus,
  output logic [7:0]  dbus,
  output logic        dbus_oe,
  input  logic [7:0]  dbus_in
);

  if (ALE_CYCLES < 1 || ALE_CYCLES > 15) begin : g_bad_ale
    $error("ALE_CYCLES out of range 1..15");
  end
  if (STB_CYCLES < 1 || STB_CYCLES > 15) begin : g_bad_stb
    $error("STB_CYCLES out of range 1..15");
  end
  if (REC_CYCLES < 2 || REC_CYCLES > 15) begin : g_bad_rec
    $error("REC_CYCLES out of range 2..15");
  end

  localparam logic [3:0] ALE_M1 = 4'(ALE_CYCLES - 1);
  localparam logic [3:0] STB_M1 = 4'(STB_CYCLES - 1);
  localparam logic [3:0] REC_M1 = 4'(REC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, HOLD, STROBE, RECOVER
  } state_t;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  cmd_t       cmd, cmd_nxt;
  logic [7:0] cap, cap_nxt;
  logic       rsp_valid_nxt;
  logic [7:0] rsp_rdata_nxt;
  logic       cs_n_nxt, ale_nxt, w_n_nxt, r_n_nxt, oe_nxt;
  logic [7:0] abus_nxt, dbus_nxt;

  cmd_t req_cmd;
  cmd_t start_cmd;
  logic start;
  logic pending;
  logic idle;

  assign req_cmd = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign idle    = (state == IDLE);

`ifdef BUS8051_MASTER_QUEUE_EN
  cmd_t       q_mem [4];
  logic [1:0] q_wp, q_rp;
  logic [2:0] q_cnt;
  logic       accept, pop, bypass, push;

  // An empty queue in IDLE hands the new command straight to the FSM.
  always_comb begin
    req_ready = (q_cnt != 3'd4);
    accept    = req_valid & req_ready;
    pop       = idle & (q_cnt != 3'd0);
    bypass    = idle & (q_cnt == 3'd0) & accept;
    push      = accept & ~bypass;
    start     = pop | bypass;
    start_cmd = pop ? q_mem[q_rp] : req_cmd;
    pending   = (q_cnt != 3'd0);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      q_wp  <= 2'd0;
      q_rp  <= 2'd0;
      q_cnt <= 3'd0;
    end else begin
      if (push) q_wp <= q_wp + 2'd1;
      if (pop)  q_rp <= q_rp + 2'd1;
      q_cnt <= q_cnt + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) q_mem[q_wp] <= req_cmd;
  end
`else
  always_comb begin
    req_ready = idle & ~rst;
    start     = req_valid & req_ready;
    start_cmd = req_cmd;
    pending   = 1'b0;
  end
`endif

  assign busy = ~idle | pending;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cmd_nxt       = cmd;
    cap_nxt       = cap;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    unique case (state)
      IDLE: if (start) begin
        state_nxt = ADDR;
        cnt_nxt   = ALE_M1;
        cmd_nxt   = start_cmd;
      end
      ADDR: begin
        if (cnt == 4'd0) state_nxt = HOLD;
        else cnt_nxt = cnt - 4'd1;
      end
      HOLD: begin
        state_nxt = STROBE;
        cnt_nxt   = STB_M1;
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = RECOVER;
          cnt_nxt   = REC_M1;
          cap_nxt   = dbus_in;
        end else cnt_nxt = cnt - 4'd1;
      end
      RECOVER: begin
        if (cnt == 4'd0) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = cmd.write ? 8'h00 : cap;
        end else cnt_nxt = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase

    // Bus pins are registered from the state being entered.
    cs_n_nxt = 1'b0;
    ale_nxt  = 1'b0;
    w_n_nxt  = 1'b1;
    r_n_nxt  = 1'b1;
    abus_nxt = abus;
    dbus_nxt = dbus;
    oe_nxt   = dbus_oe;
    unique case (state_nxt)
      IDLE: begin
        cs_n_nxt = 1'b1;
        oe_nxt   = 1'b0;
      end
      ADDR: begin
        ale_nxt  = 1'b1;
        abus_nxt = cmd_nxt.addr[15:8];
        dbus_nxt = cmd_nxt.addr[7:0];
        oe_nxt   = 1'b1;
      end
      STROBE: begin
        if (cmd_nxt.write) begin
          w_n_nxt  = 1'b0;
          dbus_nxt = cmd_nxt.wdata;
          oe_nxt   = 1'b1;
        end else begin
          r_n_nxt = 1'b0;
          oe_nxt  = 1'b0;
        end
      end
      HOLD, RECOVER: begin
        cs_n_nxt = 1'b0;
      end
      default: cs_n_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cmd       <= '0;
      cap       <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      cs_n      <= 1'b1;
      ale       <= 1'b0;
      w_n       <= 1'b1;
      r_n       <= 1'b1;
      abus      <= 8'h00;
      dbus      <= 8'h00;
      dbus_oe   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd       <= cmd_nxt;
      cap       <= cap_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      cs_n      <= cs_n_nxt;
      ale       <= ale_nxt;
      w_n       <= w_n_nxt;
      r_n       <= r_n_nxt;
      abus      <= abus_nxt;
      dbus      <= dbus_nxt;
      dbus_oe   <= oe_nxt;
    end
  end

endmodule

// File: tb/tb_bus8051_master.sv
// Directed bench for bus8051_master: default and minimum-timing instances.
// A negedge slave model tracks completed writes and bus-rule violations.
module tb_bus8051_master;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, req_valid, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata, dbus_in;
  logic        req_ready, rsp_valid, busy, cs_n, ale, w_n, r_n, dbus_oe;
  logic [7:0]  rsp_rdata, abus, dbus;

  logic        req_valid2, req_ready2, rsp_valid2, busy2;
  logic        cs_n2, ale2, w_n2, r_n2, dbus_oe2;
  logic [7:0]  rsp_rdata2, abus2, dbus2;

  bus8051_master dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .cs_n(cs_n), .ale(ale), .w_n(w_n), .r_n(r_n),
    .abus(abus), .dbus(dbus), .dbus_oe(dbus_oe), .dbus_in(dbus_in)
  );

  bus8051_master #(.ALE_CYCLES(1), .STB_CYCLES(1), .REC_CYCLES(2)) dut2 (
    .clock(clock), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
    .cs_n(cs_n2), .ale(ale2), .w_n(w_n2), .r_n(r_n2),
    .abus(abus2), .dbus(dbus2), .dbus_oe(dbus_oe2), .dbus_in(dbus_in)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // slave model and rule monitor
  logic [7:0]  din_val = 8'h00;
  logic        w_prev = 1'b1;
  logic [15:0] lat_addr = 16'h0;
  logic [15:0] sl_addr = 16'h0;
  logic [7:0]  sl_data = 8'h0;
  int sl_wr = 0, acc_cnt = 0, rsp_cnt = 0, mon_bad = 0;

  always @(negedge clock) begin
    dbus_in = r_n ? 8'h00 : din_val;
    if (!rst) begin
      if (!w_n && !r_n) mon_bad++;
      if (ale && (!w_n || !r_n)) mon_bad++;
      if (req_valid && req_ready) acc_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (ale) lat_addr = {abus, dbus};
      if (!w_prev && w_n && !cs_n) begin
        sl_wr++;
        sl_addr = lat_addr;
        sl_data = dbus;
      end
    end
    w_prev = w_n;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int n_cs, n_ale, n_w, n_r, n_oe, n_rsp, rsp_j, bad;
  logic [15:0] a1;
  logic [3:0]  hold3;
  logic        b1;
  logic [7:0]  rd;

  // Issue one command from IDLE and check its whole bus cycle.
  task automatic bus_cmd(input logic w, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] din,
                         input logic [7:0] exp_rd);
    @(posedge clock); #1;
    req_write = w; req_addr = a; req_wdata = d;
    din_val = din; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
    n_cs = 0; n_ale = 0; n_w = 0; n_r = 0; n_oe = 0;
    n_rsp = 0; rsp_j = 0; bad = 0; rd = 8'hxx;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clock);
      if (!cs_n) n_cs++;
      if (ale) n_ale++;
      if (!w_n) n_w++;
      if (!r_n) n_r++;
      if (dbus_oe) n_oe++;
      if (j == 1) begin a1 = {abus, dbus}; b1 = busy; end
      if (j == 3) hold3 = {ale, w_n, r_n, cs_n};
      if (!w_n && (dbus !== d || !dbus_oe)) bad++;
      if (!r_n && dbus_oe) bad++;
      if (rsp_valid) begin n_rsp++; rsp_j = j; rd = rsp_rdata; end
    end
    chk("addr_phase", a1, a);
    chk("busy", b1, 1);
    chk("cs_low_cycles", n_cs, 9);
    chk("ale_cycles", n_ale, 2);
    chk("hold_cycle", hold3, 4'b0110);
    chk("w_low_cycles", n_w, w ? 4 : 0);
    chk("r_low_cycles", n_r, w ? 0 : 4);
    chk("oe_cycles", n_oe, w ? 9 : 3);
    chk("strobe_data", bad, 0);
    chk("rsp_count", n_rsp, 1);
    chk("rsp_cycle", rsp_j, 10);
    chk("rsp_rdata", rd, exp_rd);
  endtask

  longint t [3];
  int hi, n2cs, n2w, n2rise, n2rsp;
  logic w2prev;
  logic [7:0] rise_data;
  int wr_before, wr_exp;
  logic rw;
  logic [15:0] ra;
  logic [7:0] rdat, rdin;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
    req_write = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outs",
        {cs_n, ale, w_n, r_n, abus, dbus, dbus_oe, rsp_valid, rsp_rdata, busy},
        {1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
`ifdef BUS8051_MASTER_QUEUE_EN
    chk("ready_in_rst", req_ready, 1);
`else
    chk("ready_in_rst", req_ready, 0);
`endif
    rst = 1'b0;

    // write 0x1234 <- 0x5A, then read 0x00FF -> 0xC3
    bus_cmd(1'b1, 16'h1234, 8'h5A, 8'h00, 8'h00);
    chk("slave_wr_count", sl_wr, 1);
    chk("slave_addr", sl_addr, 16'h1234);
    chk("slave_data", sl_data, 8'h5A);
    bus_cmd(1'b0, 16'h00FF, 8'h00, 8'hC3, 8'hC3);
    chk("slave_wr_after_read", sl_wr, 1);

    // three writes with req_valid held high
    @(posedge clock); #1;
    req_write = 1'b1; req_addr = 16'hA000; req_wdata = 8'h11;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        hi = 0;
        for (int c = 0; c < 40; c++) begin
          @(negedge clock);
          if (cs_n) hi++;
          if (req_ready) break;
        end
        chk("idle_gap", hi, 1);
      end
      @(posedge clock);
      t[i] = $time;
      #1 req_wdata = req_wdata + 8'h01;
    end
    req_valid = 1'b0;
    chk("period_01", 32'(t[1] - t[0]), 100);
    chk("period_12", 32'(t[2] - t[1]), 100);
    repeat (14) @(negedge clock);
    chk("b2b_wr_count", sl_wr, 4);
    chk("b2b_last_addr", sl_addr, 16'hA000);
    chk("b2b_last_data", sl_data, 8'h13);

    // reset during the strobe of a write
    @(posedge clock); #1;
    req_write = 1'b1; req_addr = 16'h5555; req_wdata = 8'h66;
    req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    repeat (5) @(negedge clock);
    chk("pre_rst_strobe", w_n, 0);
    #1 rst = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_outs", {w_n, cs_n, dbus_oe, rsp_valid, busy, ale, r_n},
        7'b1100001);
`ifdef BUS8051_MASTER_QUEUE_EN
    chk("rst_mid_ready", req_ready, 1);
`else
    chk("rst_mid_ready", req_ready, 0);
`endif
    rst = 1'b0;
    n_rsp = 0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clock);
      if (rsp_valid) n_rsp++;
    end
    chk("rst_no_rsp", n_rsp, 0);
    chk("rst_no_write", sl_wr, 4);

    // minimum timing instance
    @(posedge clock); #1;
    req_write = 1'b1; req_addr = 16'h0BEE; req_wdata = 8'h77;
    req_valid2 = 1'b1;
    chk("dut2_ready", req_ready2, 1);
    @(posedge clock); #1 req_valid2 = 1'b0;
    n2cs = 0; n2w = 0; n2rise = 0; n2rsp = 0;
    w2prev = 1'b1; rise_data = 8'h00;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clock);
      if (!cs_n2) n2cs++;
      if (!w_n2) n2w++;
      if (!w2prev && w_n2 && !cs_n2) begin n2rise++; rise_data = dbus2; end
      if (rsp_valid2) n2rsp = j;
      w2prev = w_n2;
    end
    chk("dut2_cs_cycles", n2cs, 5);
    chk("dut2_w_cycles", n2w, 1);
    chk("dut2_write_seen", n2rise, 1);
    chk("dut2_write_data", rise_data, 8'h77);
    chk("dut2_rsp_cycle", n2rsp, 6);

    // random commands
    wr_before = sl_wr;
    wr_exp = 0;
    for (int i = 0; i < 6; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rdat = 8'($urandom);
      rdin = 8'($urandom);
      if (rw) wr_exp++;
      bus_cmd(rw, ra, rdat, rdin, rw ? 8'h00 : rdin);
    end
    chk("rand_wr_count", sl_wr - wr_before, wr_exp);

    chk("bus_rules", mon_bad, 0);
    chk("accept_total", acc_cnt, 12);
    chk("rsp_total", rsp_cnt, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
